// File: rtl/conv_tiling_v3.sv
// conv_tiling_v3: walks the four-deep convolution tiling loop nest.
// Loops are input channel, x, y and output channel, and order is selectable.
// One tile descriptor is presented per valid/ready handshake.
module conv_tiling_v3 #(
  parameter int PIX_X = 32,
  parameter int PIX_Y = 3,
  parameter int PIX_O = 16,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] cfg_ox,
  input  logic [W-1:0] cfg_oy,
  input  logic [W-1:0] cfg_nif,
  input  logic [W-1:0] cfg_nof,
  input  logic         cfg_order,
  input  logic         start,
  input  logic         abort,
  input  logic         tile_ready,
  output logic         tile_valid,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] ox_start,
  output logic [W-1:0] oy_start,
  output logic [W-1:0] of_start,
  output logic [W-1:0] if_idx,
  output logic [W-1:0] pox,
  output logic [W-1:0] poy,
  output logic [W-1:0] pof,
  output logic [W-1:0] row_base,
  output logic         first_if,
  output logic         last_if,
  output logic         last_tile
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [W-1:0] LP_ONE   = W'(1);
  localparam logic [W-1:0] LP_PX    = W'(PIX_X);
  localparam logic [W-1:0] LP_PY    = W'(PIX_Y);
  localparam logic [W-1:0] LP_PO    = W'(PIX_O);
  localparam logic [W:0]   LP_ONE_E = (W+1)'(1);
  localparam logic [W:0]   LP_PX_E  = (W+1)'(PIX_X);
  localparam logic [W:0]   LP_PY_E  = (W+1)'(PIX_Y);
  localparam logic [W:0]   LP_PO_E  = (W+1)'(PIX_O);

  state_t       r_state;
  state_t       w_state_next;
  logic [W-1:0] r_ox, r_oy, r_nif, r_nof;
  logic         r_order;
  logic [W-1:0] r_x, r_y, r_o, r_if, r_row_base;

  logic w_if_wrap, w_x_wrap, w_y_wrap, w_o_wrap;
  logic w_x_step, w_y_step, w_o_step;
  logic w_hs, w_cfg_zero, w_launch;

  // Sums are widened by one bit so dimensions close to 2^W-1 cannot wrap.
  assign w_if_wrap = ({1'b0, r_if} + LP_ONE_E) > {1'b0, r_nif};
  assign w_x_wrap  = ({1'b0, r_x} + LP_PX_E) > {1'b0, r_ox};
  assign w_y_wrap  = ({1'b0, r_y} + LP_PY_E) > {1'b0, r_oy};
  assign w_o_wrap  = ({1'b0, r_o} + LP_PO_E) > {1'b0, r_nof};

  // An outer loop steps only when every loop inside it wraps together.
  assign w_x_step  = r_order ? (w_if_wrap && w_y_wrap) : w_if_wrap;
  assign w_y_step  = r_order ? w_if_wrap : (w_if_wrap && w_x_wrap);
  assign w_o_step  = w_if_wrap && w_x_wrap && w_y_wrap;
  assign last_tile = w_o_step && w_o_wrap;

  assign w_hs       = (r_state == RUN) && tile_ready && !abort;
  assign w_cfg_zero = (cfg_ox == '0) || (cfg_oy == '0) || (cfg_nif == '0) || (cfg_nof == '0);
  assign w_launch   = (r_state == IDLE) && start && !abort;

  assign tile_valid = (r_state == RUN);
  assign done       = (r_state == DONE);
  assign busy       = (r_state != IDLE);
  assign ox_start   = r_x;
  assign oy_start   = r_y;
  assign of_start   = r_o;
  assign if_idx     = r_if;
  assign row_base   = r_row_base;
  assign first_if   = (r_if == LP_ONE);
  assign last_if    = (r_if == r_nif);

  // Partial tile sizes at the right/bottom/channel edges.
  assign pox = (({1'b0, r_x} + LP_PX_E - LP_ONE_E) > {1'b0, r_ox}) ? (r_ox - r_x + LP_ONE) : LP_PX;
  assign poy = (({1'b0, r_y} + LP_PY_E - LP_ONE_E) > {1'b0, r_oy}) ? (r_oy - r_y + LP_ONE) : LP_PY;
  assign pof = (({1'b0, r_o} + LP_PO_E - LP_ONE_E) > {1'b0, r_nof}) ? (r_nof - r_o + LP_ONE) : LP_PO;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic; abort wins over start and over a handshake.
  always_comb begin
    w_state_next = r_state;
    if (abort) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (start) w_state_next = w_cfg_zero ? DONE : RUN;
        RUN:     if (tile_ready && last_tile) w_state_next = DONE;
        DONE:    w_state_next = IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  // Layer configuration is captured only when a layer is launched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ox    <= '0;
      r_oy    <= '0;
      r_nif   <= '0;
      r_nof   <= '0;
      r_order <= 1'b0;
    end else if (w_launch) begin
      r_ox    <= cfg_ox;
      r_oy    <= cfg_oy;
      r_nif   <= cfg_nif;
      r_nof   <= cfg_nof;
      r_order <= cfg_order;
    end
  end

  // Loop counters: cleared on abort/launch, advanced on each handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x        <= LP_ONE;
      r_y        <= LP_ONE;
      r_o        <= LP_ONE;
      r_if       <= LP_ONE;
      r_row_base <= '0;
    end else if (abort || w_launch) begin
      r_x        <= LP_ONE;
      r_y        <= LP_ONE;
      r_o        <= LP_ONE;
      r_if       <= LP_ONE;
      r_row_base <= '0;
    end else if (w_hs) begin
      r_if <= w_if_wrap ? LP_ONE : (r_if + LP_ONE);
      if (w_x_step) r_x <= w_x_wrap ? LP_ONE : (r_x + LP_PX);
      if (w_y_step) begin
        r_y        <= w_y_wrap ? LP_ONE : (r_y + LP_PY);
        r_row_base <= w_y_wrap ? '0 : (r_row_base + LP_ONE);
      end
      if (w_o_step) r_o <= w_o_wrap ? LP_ONE : (r_o + LP_PO);
    end
  end

endmodule

// File: tb/tb_conv_tiling_v3.sv
// Directed testbench for conv_tiling_v3 with hand-computed tile tables.
module tb_conv_tiling_v3;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] cfg_ox, cfg_oy, cfg_nif, cfg_nof;
  logic         cfg_order, start, abort, tile_ready;
  logic         tile_valid, busy, done;
  logic [W-1:0] ox_start, oy_start, of_start, if_idx, pox, poy, pof, row_base;
  logic         first_if, last_if, last_tile;

  int total = 0;
  int bad   = 0;

  // Expected tile tables for ox=70, oy=7, nof=20 with 32x3x16 tiles.
  int xs[3]  = '{1, 33, 65};
  int pxs[3] = '{32, 32, 6};
  int ys[3]  = '{1, 4, 7};
  int pys[3] = '{3, 3, 1};
  int rbs[3] = '{0, 1, 2};
  int os[2]  = '{1, 17};
  int pos[2] = '{16, 4};

  conv_tiling_v3 #(.PIX_X(32), .PIX_Y(3), .PIX_O(16), .W(W)) dut (
    .clk(clk), .reset(reset),
    .cfg_ox(cfg_ox), .cfg_oy(cfg_oy), .cfg_nif(cfg_nif), .cfg_nof(cfg_nof),
    .cfg_order(cfg_order), .start(start), .abort(abort), .tile_ready(tile_ready),
    .tile_valid(tile_valid), .busy(busy), .done(done),
    .ox_start(ox_start), .oy_start(oy_start), .of_start(of_start), .if_idx(if_idx),
    .pox(pox), .poy(poy), .pof(pof), .row_base(row_base),
    .first_if(first_if), .last_if(last_if), .last_tile(last_tile)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int ox, input int oy, input int nif, input int nof, input bit order);
    cfg_ox    = W'(ox);
    cfg_oy    = W'(oy);
    cfg_nif   = W'(nif);
    cfg_nof   = W'(nof);
    cfg_order = order;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    cfg_ox    = '0;
    cfg_oy    = '0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    total++;
    if ({tile_valid, busy, done} !== 3'b000) begin
      bad++;
      $display("[TB] FAIL reset_flags: got v/b/d=%b required 000", {tile_valid, busy, done});
    end
    total++;
    if ({ox_start, oy_start, of_start, if_idx, row_base} !== {16'd1, 16'd1, 16'd1, 16'd1, 16'd0}) begin
      bad++;
      $display("[TB] FAIL reset_counters: got x=%0d y=%0d o=%0d if=%0d rb=%0d required 1 1 1 1 0",
               ox_start, oy_start, of_start, if_idx, row_base);
    end
    total++;
    if ({pox, poy, pof} !== 48'd0) begin
      bad++;
      $display("[TB] FAIL reset_sizes: got pox=%0d poy=%0d pof=%0d required 0 0 0", pox, poy, pof);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_order0;
    int n = 0;
    do_start(70, 7, 2, 20, 1'b0);
    for (int o = 0; o < 2; o++)
      for (int y = 0; y < 3; y++)
        for (int x = 0; x < 3; x++)
          for (int i = 0; i < 2; i++) begin
            bit exp_last = (o == 1 && y == 2 && x == 2 && i == 1);
            total++;
            if (tile_valid !== 1'b1 || if_idx !== W'(i + 1) || ox_start !== W'(xs[x]) ||
                pox !== W'(pxs[x]) || oy_start !== W'(ys[y]) || poy !== W'(pys[y]) ||
                row_base !== W'(rbs[y]) || of_start !== W'(os[o]) || pof !== W'(pos[o])) begin
              bad++;
              $display("[TB] FAIL order0_tile%0d: got v=%b if=%0d x=%0d px=%0d y=%0d py=%0d rb=%0d o=%0d po=%0d required 1 %0d %0d %0d %0d %0d %0d %0d %0d",
                       n + 1, tile_valid, if_idx, ox_start, pox, oy_start, poy, row_base, of_start, pof,
                       i + 1, xs[x], pxs[x], ys[y], pys[y], rbs[y], os[o], pos[o]);
            end
            total++;
            if ({first_if, last_if, last_tile} !== {i == 0, i == 1, exp_last}) begin
              bad++;
              $display("[TB] FAIL order0_flags%0d: got f/l/lt=%b required %b", n + 1,
                       {first_if, last_if, last_tile}, {i == 0, i == 1, exp_last});
            end
            if (tile_valid && tile_ready) n++;
            tick();
          end
    total++;
    if (n !== 36) begin
      bad++;
      $display("[TB] FAIL order0_count: got %0d required 36", n);
    end
    total++;
    if ({tile_valid, busy, done} !== 3'b011) begin
      bad++;
      $display("[TB] FAIL order0_done: got v/b/d=%b required 011", {tile_valid, busy, done});
    end
    tick();
    total++;
    if ({tile_valid, busy, done} !== 3'b000) begin
      bad++;
      $display("[TB] FAIL order0_idle: got v/b/d=%b required 000", {tile_valid, busy, done});
    end
  endtask

  task automatic test_order1;
    int n = 0;
    bit ended = 1'b0;
    do_start(70, 7, 2, 20, 1'b1);
    total++;
    if ({if_idx, ox_start, oy_start} !== {16'd1, 16'd1, 16'd1}) begin
      bad++;
      $display("[TB] FAIL order1_t1: got if=%0d x=%0d y=%0d required 1 1 1", if_idx, ox_start, oy_start);
    end
    tick();
    total++;
    if ({if_idx, ox_start, oy_start} !== {16'd2, 16'd1, 16'd1}) begin
      bad++;
      $display("[TB] FAIL order1_t2: got if=%0d x=%0d y=%0d required 2 1 1", if_idx, ox_start, oy_start);
    end
    tick();
    total++;
    if ({if_idx, ox_start, oy_start, row_base} !== {16'd1, 16'd1, 16'd4, 16'd1}) begin
      bad++;
      $display("[TB] FAIL order1_t3: got if=%0d x=%0d y=%0d rb=%0d required 1 1 4 1",
               if_idx, ox_start, oy_start, row_base);
    end
    n = 3;
    for (int k = 0; k < 100 && !ended; k++) begin
      tick();
      if (!tile_valid) ended = 1'b1;
      else n++;
    end
    total++;
    if (n !== 36 || done !== 1'b1) begin
      bad++;
      $display("[TB] FAIL order1_count: got n=%0d done=%b required 36 1", n, done);
    end
    tick();
  endtask

  task automatic test_stall;
    do_start(70, 7, 2, 20, 1'b0);
    tick();
    tick();
    tile_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      total++;
      if ({tile_valid, if_idx, ox_start, pox, oy_start, of_start, row_base} !==
          {1'b1, 16'd1, 16'd33, 16'd32, 16'd1, 16'd1, 16'd0}) begin
        bad++;
        $display("[TB] FAIL stall_hold%0d: got v=%b if=%0d x=%0d px=%0d y=%0d o=%0d rb=%0d required 1 1 33 32 1 1 0",
                 k, tile_valid, if_idx, ox_start, pox, oy_start, of_start, row_base);
      end
    end
    tile_ready = 1'b1;
    tick();
    total++;
    if ({if_idx, ox_start} !== {16'd2, 16'd33}) begin
      bad++;
      $display("[TB] FAIL stall_resume: got if=%0d x=%0d required 2 33", if_idx, ox_start);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
  endtask

  task automatic test_zero_dim;
    do_start(0, 7, 2, 20, 1'b0);
    total++;
    if ({tile_valid, busy, done} !== 3'b011) begin
      bad++;
      $display("[TB] FAIL zero_done: got v/b/d=%b required 011", {tile_valid, busy, done});
    end
    tick();
    total++;
    if ({tile_valid, busy, done} !== 3'b000) begin
      bad++;
      $display("[TB] FAIL zero_idle: got v/b/d=%b required 000", {tile_valid, busy, done});
    end
  endtask

  task automatic test_abort_reset;
    do_start(70, 7, 2, 20, 1'b0);
    for (int k = 0; k < 9; k++) tick();
    total++;
    if ({if_idx, ox_start, oy_start, row_base} !== {16'd2, 16'd33, 16'd4, 16'd1}) begin
      bad++;
      $display("[TB] FAIL abort_tile10: got if=%0d x=%0d y=%0d rb=%0d required 2 33 4 1",
               if_idx, ox_start, oy_start, row_base);
    end
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    total++;
    if ({tile_valid, busy, done, ox_start, oy_start, of_start, if_idx, row_base} !==
        {3'b000, 16'd1, 16'd1, 16'd1, 16'd1, 16'd0}) begin
      bad++;
      $display("[TB] FAIL abort_idle: got v/b/d=%b x=%0d y=%0d o=%0d if=%0d rb=%0d required 000 1 1 1 1 0",
               {tile_valid, busy, done}, ox_start, oy_start, of_start, if_idx, row_base);
    end
    tick();
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL abort_nodone: got done=%b required 0", done);
    end
    do_start(70, 7, 2, 20, 1'b0);
    total++;
    if ({tile_valid, if_idx, ox_start, oy_start} !== {1'b1, 16'd1, 16'd1, 16'd1}) begin
      bad++;
      $display("[TB] FAIL abort_replay: got v=%b if=%0d x=%0d y=%0d required 1 1 1 1",
               tile_valid, if_idx, ox_start, oy_start);
    end
    tick();
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({tile_valid, busy, done, ox_start, if_idx, row_base} !== {3'b000, 16'd1, 16'd1, 16'd0}) begin
      bad++;
      $display("[TB] FAIL reset_mid: got v/b/d=%b x=%0d if=%0d rb=%0d required 000 1 1 0",
               {tile_valid, busy, done}, ox_start, if_idx, row_base);
    end
    tick();
    reset = 1'b0;
    tick();
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_nodone: got done=%b busy=%b required 0 0", done, busy);
    end
    do_start(70, 7, 2, 20, 1'b0);
    tick();
    total++;
    if ({tile_valid, if_idx, ox_start} !== {1'b1, 16'd2, 16'd1}) begin
      bad++;
      $display("[TB] FAIL reset_replay: got v=%b if=%0d x=%0d required 1 2 1", tile_valid, if_idx, ox_start);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
  endtask

  task automatic test_big;
    int n = 0;
    bit seen = 1'b0;
    do_start(65535, 1, 1, 1, 1'b0);
    for (int k = 0; k < 3000 && !seen; k++) begin
      if (tile_valid) begin
        n++;
        if (last_tile) begin
          seen = 1'b1;
          total++;
          if ({ox_start, pox, poy, pof} !== {16'd65505, 16'd31, 16'd1, 16'd1}) begin
            bad++;
            $display("[TB] FAIL big_last: got x=%0d px=%0d py=%0d pf=%0d required 65505 31 1 1",
                     ox_start, pox, poy, pof);
          end
        end
      end
      tick();
    end
    total++;
    if (!seen || n !== 2048) begin
      bad++;
      $display("[TB] FAIL big_count: got seen=%b n=%0d required 1 2048", seen, n);
    end
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("[TB] FAIL big_done: got done=%b required 1", done);
    end
    tick();
  endtask

  initial begin
    reset      = 1'b1;
    cfg_ox     = '0;
    cfg_oy     = '0;
    cfg_nif    = '0;
    cfg_nof    = '0;
    cfg_order  = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    tile_ready = 1'b1;
    test_reset();
    test_order0();
    test_order1();
    test_stall();
    test_zero_dim();
    test_abort_reset();
    test_big();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_tiling_v3.md
CONV_TILING_V3 -- requirements
Module: conv_tiling_v3

Interface
REQ-001 SHALL have parameter PIX_X, default 32: output columns per tile (x step).
REQ-002 SHALL have parameter PIX_Y, default 3: output rows per tile (y step, row-buffer count).
REQ-003 SHALL have parameter PIX_O, default 16: output channels per tile (o step).
REQ-004 SHALL have parameter W, default 16: width of every dimension, coordinate and count port.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have ports cfg_ox, cfg_oy, cfg_nif, cfg_nof, input, W bits each: output width, output height, input-channel count, output-channel count.
REQ-008 SHALL have port cfg_order, input, 1 bit: 0 = loop nest if, x, y, o (innermost first); 1 = if, y, x, o.
REQ-009 SHALL have ports start, input, 1 bit (begin a layer) and abort, input, 1 bit (synchronous cancel).
REQ-010 SHALL have port tile_ready, input, 1 bit: consumer accepts the current tile.
REQ-011 SHALL have ports tile_valid, busy and done, output, 1 bit each.
REQ-012 SHALL have ports ox_start, oy_start, of_start, if_idx, pox, poy, pof and row_base, output, W bits each.
REQ-013 SHALL have ports first_if, last_if and last_tile, output, 1 bit each.

Function
REQ-014 SHALL implement states IDLE, RUN and DONE; reset and abort force IDLE.
REQ-015 In IDLE, start=1 SHALL latch all cfg_* ports into internal registers and enter RUN on the next edge; cfg_* changes during RUN SHALL be ignored.
REQ-016 On start, if any latched dimension is 0, the block SHALL go to DONE without ever asserting tile_valid.
REQ-017 tile_valid SHALL equal 1 exactly in RUN; the first tile SHALL be presented in the cycle after start.
REQ-018 A handshake is tile_valid and tile_ready both 1 on the same edge; all tile outputs SHALL hold stable while tile_valid=1 and tile_ready=0.
REQ-019 Coordinates SHALL be 1-based: ox_start and oy_start begin at 1, of_start at 1, and if_idx at 1.
REQ-020 Steps per handshake: if_idx +1, x +PIX_X, y +PIX_Y with row_base +1, o +PIX_O.
REQ-021 Carry rules: if_idx wraps to 1 when if_idx+1 > nif.
REQ-022 Carry rules: x wraps to 1 when x+PIX_X > ox.
REQ-023 Carry rules: y wraps to 1, with row_base to 0, when y+PIX_Y > oy.
REQ-024 Carry into a loop SHALL occur only when every inner loop wraps on the same handshake, in the order selected by cfg_order.
REQ-025 pox SHALL be ox-ox_start+1 when ox_start+PIX_X-1 > ox, else PIX_X; poy and pof SHALL follow the same rule with oy, PIX_Y and nof, PIX_O.
REQ-026 Overflow-safe compares: every sum in REQ-021..REQ-025 SHALL be evaluated at W+1 bits, so no wrap-around occurs for dimensions near 2^W-1.
REQ-027 first_if SHALL be 1 when if_idx=1, and last_if SHALL be 1 when if_idx=nif, both combinationally.
REQ-028 last_tile SHALL be 1 when all four loops are at their final value.
REQ-029 A handshake with last_tile=1 SHALL move RUN to DONE.
REQ-030 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-031 busy SHALL be 1 in RUN and DONE and 0 in IDLE; start SHALL be ignored unless in IDLE.
REQ-032 abort=1 in any state SHALL go to IDLE on the next edge and reset the counters; done SHALL not pulse; abort SHALL override start and a handshake in the same cycle.
REQ-033 Total handshakes per layer SHALL equal nif * ceil(ox/PIX_X) * ceil(oy/PIX_Y) * ceil(nof/PIX_O).

Reset
REQ-034 While reset=1, state SHALL be IDLE and tile_valid, busy and done SHALL be 0.
REQ-035 While reset=1, ox_start, oy_start, of_start and if_idx SHALL be 1, and row_base SHALL be 0.
REQ-036 While reset=1, the latched configuration SHALL be 0, so pox, poy and pof read 0.
REQ-037 Reset asserted mid-layer SHALL discard the layer with no done pulse.

Verification
REQ-038 With PIX_X=32, PIX_Y=3, PIX_O=16, ox=70, oy=7, nif=2, nof=20, order=0 and ready held at 1: apply start. Required: 36 handshakes; ox_start sequence 1,33,65 with pox 32,32,6; oy_start 1,4,7 with poy 3,3,1 and row_base 0,1,2; of_start 1,17 with pof 16,4; done pulses one cycle after handshake 36.
REQ-039 Same configuration with order=1. Required: after the first two handshakes (if 1,2), oy_start steps 1 to 4 while ox_start stays 1.
REQ-040 Hold ready=0 for 5 cycles on tile 3. Required: all outputs stay constant and no counter advances.
REQ-041 Configure ox=0. Required: tile_valid stays 0, done pulses in the cycle after RUN would begin, busy is 1 for one cycle.
REQ-042 Assert abort on tile 10, and separately assert async reset mid-layer. Required in both cases: IDLE, counters at 1, no done pulse; a following start replays the sequence from tile 1.
REQ-043 Configure ox=65535, nif=1, oy=1, nof=1. Required: final pox=31 and last_tile asserted, with no counter overflow.
